ipd_ctrl_sat: RTL and testbench
===============================

Name: ipd_ctrl_sat

Overview:
- Parametrised, truncating/saturating successor to the current I-PD servo controller.
- Computes a discrete I-PD law: the integral acts on error; proportional and derivative act on the measurement only.
- Uses one shared multiplier, time-multiplexed by a small FSM.
- Sits between the ADC/UART receive path (Pot, Ref strobed by Rx_En) and the PWM generator; emits a W-bit saturated command plus Done/Sat status.

Parameters:
cant_bits, 16, data width W of Pot, Ref, gains and Yk (signed two's complement)
frac_bits, 8, fractional bits F of the gain format (Q(W-F-1).F); must be 1..W-2
ACC_W (localparam), 2*cant_bits+4, internal accumulator width

Ports:
Clk_G  in  1  system clock, rising edge
Rst_G  in  1  asynchronous reset, active-high
Rx_En  in  1  one-cycle strobe: new Pot/Ref sample valid
Clr_St  in  1  synchronous clear of integrator and measurement history
Pot  in  W  measured position, signed
Ref  in  W  setpoint, signed
Kp  in  W  proportional gain, signed Q.F, held stable while Busy
Ki  in  W  integral gain, signed Q.F
Kd  in  W  derivative gain, signed Q.F
Yk  out  W  saturated, rounded control output, registered
Done  out  1  one-cycle pulse when Yk updates
Busy  out  1  high from accepted strobe until Done
Sat  out  1  registered; high when the last Yk was clamped

Behaviour:
- Reset (async, Rst_G=1): Yk=0, Done=0, Busy=0, Sat=0; u_acc=0, y1=0, y2=0; FSM=IDLE. This applies at any cycle, mid-computation included; the partial result is discarded.
- Control law: e=Ref-Pot (W+1 b); dy=Pot-y1 (W+1 b); d2y=Pot-2*y1+y2 (W+2 b).
- Update: u_acc += Ki*e - Kp*dy - Kd*d2y. Products are sign-extended to ACC_W.
- Every accumulator add/subtract saturates at the ACC_W signed limits; it never wraps.
- FSM states IDLE, DIFF, MUL_I, MUL_P, MUL_D, OUT; one cycle per state.
  - IDLE: Rx_En=1 at an edge latches Pot/Ref, sets Busy, and moves to DIFF. Otherwise the FSM stays in IDLE.
  - DIFF: registers e, dy, d2y.
  - MUL_I, MUL_P, MUL_D: one multiply-accumulate each.
  - OUT: computes r = (u_acc + 2^(F-1)) >>> F (round half up). Yk = clamp(r, -2^(W-1), 2^(W-1)-1); Sat = (clamped). Also y2<=y1, y1<=latched Pot, Done=1, Busy=0, then returns to IDLE.
- Latency: the strobe edge is edge 0; Yk/Done update at edge 5. The earliest next accepted strobe is at edge 5, giving a throughput of one sample per 5 cycles.
- Rx_En while Busy: ignored (no queuing, no error).
- Clr_St=1 at an edge in IDLE zeroes u_acc, y1, y2. Yk holds its value and Sat clears. Clr_St has priority over a simultaneous Rx_En, so that strobe is dropped.
- Clr_St while Busy: ignored.
- First sample after reset/clear: history is zero, so a derivative kick is expected behaviour.
- Gain changes while Busy: the result is undefined. The bench must not do this.

Optional Feature:
ANTI_WINDUP_EN
- Defined: in OUT, if clamped, u_acc is reloaded with (Yk_clamped <<< F). The integrator never exceeds the output range, so recovery starts on the first reversed-error sample.
- Undefined: u_acc retains its unclamped value (subject only to ACC_W saturation). Recovery is delayed until the accumulated excess unwinds.

Decomposition:
- Package ipd_pkg: FSM state encoding; ACC_W derivation; the sat_add helper function; the rounding constant.
- One sub-module, ipd_mac: signed W x (W+2) multiplier plus saturating ACC_W adder/subtractor with an add/sub select. It is instantiated once.
- Top module: FSM, history registers, output clamp.

Test Plan:
- Reset/idle: Rst_G pulsed 10 ns at start -> Yk=0, Done=0, Busy=0, Sat=0. Then Rst_G asserted at edge 3 of a computation -> all outputs 0 immediately; no Done appears.
- Integral ramp (W=16, F=8): Ki=256, Kp=Kd=0, Ref=256, Pot=0, three strobes 16 cycles apart -> Yk=256, 512, 768. Each Done comes exactly 5 edges after its strobe; Sat=0.
- Proportional on measurement: Ki=Kd=0, Kp=256, Pot sequence 0, 256, 256 -> Yk=0, -256, -256.
- Derivative: Kp=Ki=0, Kd=256, Pot sequence 0, 256, 256 -> Yk=0, -256, -256 + 256 = 0 (d2y = 256, then -256).
- Saturation/anti-windup: Ki=32767, Ref=32767, Pot=-32768, four strobes -> Yk=32767, Sat=1. Then Ref=0, Pot=256, Ki=256 -> with ANTI_WINDUP_EN Yk=32511 on the next sample; without it Yk stays 32767.
- Handshake: Rx_En pulsed at edges 0 and 2 -> one Done only, at edge 5. Rx_En and Clr_St together in IDLE -> no Busy; u_acc cleared, so the next strobe with Ki=256, e=256 gives Yk=256.

Source files
------------

// File: rtl/ipd_pkg.sv
// ipd_pkg -- shared definitions for the I-PD controller.
//   ipd_state_e : FSM state encoding (one cycle per state)
//   acc_width   : accumulator width derived from the data width
//   round_const : round-half-up constant 2^(F-1)
//   sat_add     : saturating add/subtract at a run-time accumulator width
// The helpers work on MAX_ACC_W-bit values so that one package serves any
// cant_bits up to 32. Callers sign-extend into, and size-cast out of, that width.
package ipd_pkg;

    localparam int MAX_ACC_W = 72;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DIFF  = 3'd1,
        ST_MUL_I = 3'd2,
        ST_MUL_P = 3'd3,
        ST_MUL_D = 3'd4,
        ST_OUT   = 3'd5
    } ipd_state_e;

    function automatic int acc_width(input int w);
        return (32'sd2 * w) + 32'sd4;
    endfunction

    function automatic logic signed [MAX_ACC_W-1:0] round_const(input int f);
        logic signed [MAX_ACC_W-1:0] one_v;
        one_v = {{(MAX_ACC_W-1){1'b0}}, 1'b1};
        return one_v <<< (f - 32'sd1);
    endfunction

    // a +/- b, clamped to the signed range of an acc_w-bit word (never wraps)
    function automatic logic signed [MAX_ACC_W-1:0] sat_add(
        input logic signed [MAX_ACC_W-1:0] a,
        input logic signed [MAX_ACC_W-1:0] b,
        input logic                        sub,
        input int                          acc_w
    );
        logic signed [MAX_ACC_W:0] one_v;
        logic signed [MAX_ACC_W:0] max_v;
        logic signed [MAX_ACC_W:0] min_v;
        logic signed [MAX_ACC_W:0] sum_v;
        one_v = {{MAX_ACC_W{1'b0}}, 1'b1};
        max_v = (one_v <<< (acc_w - 32'sd1)) - one_v;
        min_v = -(one_v <<< (acc_w - 32'sd1));
        if (sub) begin
            sum_v = {a[MAX_ACC_W-1], a} - {b[MAX_ACC_W-1], b};
        end else begin
            sum_v = {a[MAX_ACC_W-1], a} + {b[MAX_ACC_W-1], b};
        end
        if (sum_v > max_v) begin
            sum_v = max_v;
        end else if (sum_v < min_v) begin
            sum_v = min_v;
        end else begin
            sum_v = sum_v;
        end
        return sum_v[MAX_ACC_W-1:0];
    endfunction

endpackage

// File: rtl/ipd_mac.sv
// ipd_mac -- shared multiply-accumulate unit of the I-PD controller.
// Purely combinational: acc_out = sat(acc_in +/- mul_a * mul_b).
// Ports:
//   mul_a   in  W      signed gain
//   mul_b   in  W+2    signed difference term (e, dy or d2y)
//   acc_in  in  ACC_W  current accumulator
//   sub_sel in  1      1 = subtract product, 0 = add product
//   acc_out out ACC_W  saturated result
module ipd_mac
    import ipd_pkg::*;
#(
    parameter int W     = 16,
    parameter int ACC_W = 36
) (
    input  logic signed [W-1:0]     mul_a,
    input  logic signed [W+1:0]     mul_b,
    input  logic signed [ACC_W-1:0] acc_in,
    input  logic                    sub_sel,
    output logic signed [ACC_W-1:0] acc_out
);

    logic signed [2*W+1:0]       prod_s;
    logic signed [MAX_ACC_W-1:0] acc_ext_s;
    logic signed [MAX_ACC_W-1:0] prod_ext_s;

    // full-precision product, both operands sign-extended, then saturating accumulate
    always_comb begin
        prod_s     = mul_a * mul_b;
        acc_ext_s  = {{(MAX_ACC_W-ACC_W){acc_in[ACC_W-1]}}, acc_in};
        prod_ext_s = {{(MAX_ACC_W-2*W-2){prod_s[2*W+1]}}, prod_s};
        acc_out    = ACC_W'(sat_add(acc_ext_s, prod_ext_s, sub_sel, ACC_W));
    end

endmodule

// File: rtl/ipd_ctrl_sat.sv
// ipd_ctrl_sat -- discrete I-PD servo controller with saturating arithmetic.
// Integral acts on e = Ref - Pot; proportional and derivative act on the
// measurement only: u_acc += Ki*e - Kp*dy - Kd*d2y, one shared MAC, one
// product per cycle. Output is u_acc rounded half-up by F bits, clamped to W bits.
// Optional build macro: ANTI_WINDUP_EN -- when the output clamps, the
// integrator is reloaded with the clamped output so it cannot wind up.
// Ports:
//   Clk_G  in   clock, rising edge
//   Rst_G  in   asynchronous reset, active-high
//   Rx_En  in   one-cycle strobe, new Pot/Ref sample valid
//   Clr_St in   synchronous clear of integrator and history (idle only)
//   Pot    in   W  measured position (signed)
//   Ref    in   W  setpoint (signed)
//   Kp/Ki/Kd in W  gains, signed Q(W-F-1).F, stable while Busy
//   Yk     out  W  registered saturated command
//   Done   out  one-cycle pulse when Yk updates
//   Busy   out  high from accepted strobe until Done
//   Sat    out  high when the last Yk was clamped
module ipd_ctrl_sat
    import ipd_pkg::*;
#(
    parameter int cant_bits = 16,
    parameter int frac_bits = 8
) (
    input  logic                 Clk_G,
    input  logic                 Rst_G,
    input  logic                 Rx_En,
    input  logic                 Clr_St,
    input  logic [cant_bits-1:0] Pot,
    input  logic [cant_bits-1:0] Ref,
    input  logic [cant_bits-1:0] Kp,
    input  logic [cant_bits-1:0] Ki,
    input  logic [cant_bits-1:0] Kd,
    output logic [cant_bits-1:0] Yk,
    output logic                 Done,
    output logic                 Busy,
    output logic                 Sat
);

    localparam int W     = cant_bits;
    localparam int ACC_W = acc_width(cant_bits);
    localparam logic signed [ACC_W:0] ONE_C    = {{ACC_W{1'b0}}, 1'b1};
    localparam logic signed [ACC_W:0] YK_MAX_C = (ONE_C <<< (W - 32'sd1)) - ONE_C;
    localparam logic signed [ACC_W:0] YK_MIN_C = -(ONE_C <<< (W - 32'sd1));
    localparam logic signed [ACC_W:0] RND_C    = (ACC_W+1)'(round_const(frac_bits));

    ipd_state_e state_r;
    ipd_state_e state_nx_s;
    logic       accept_s;
    logic       clear_s;

    logic signed [W-1:0]     pot_lat_r;
    logic signed [W-1:0]     ref_lat_r;
    logic signed [W-1:0]     y1_r;
    logic signed [W-1:0]     y2_r;
    logic signed [W:0]       e_r;
    logic signed [W:0]       dy_r;
    logic signed [W+1:0]     d2y_r;
    logic signed [W:0]       e_s;
    logic signed [W:0]       dy_s;
    logic signed [W+1:0]     d2y_s;
    logic signed [ACC_W-1:0] u_acc_r;

    logic signed [W-1:0]     mul_a_s;
    logic signed [W+1:0]     mul_b_s;
    logic                    sub_sel_s;
    logic signed [ACC_W-1:0] mac_out_s;

    logic signed [ACC_W:0]   rnd_s;
    logic signed [ACC_W:0]   r_s;
    logic signed [W-1:0]     yk_clamp_s;
    logic                    clamped_s;

    logic [W-1:0] yk_r;
    logic         done_r;
    logic         busy_r;
    logic         sat_r;

    // FSM state register
    always_ff @(posedge Clk_G or posedge Rst_G) begin
        if (Rst_G) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // next state plus accept/clear decisions; OUT doubles as an accept slot
    // so back-to-back samples run at one per five cycles
    always_comb begin
        state_nx_s = state_r;
        accept_s   = 1'b0;
        clear_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (Clr_St) begin
                    clear_s    = 1'b1;      // clear wins; a coincident strobe is dropped
                    state_nx_s = ST_IDLE;
                end else if (Rx_En) begin
                    accept_s   = 1'b1;
                    state_nx_s = ST_DIFF;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_DIFF:  state_nx_s = ST_MUL_I;
            ST_MUL_I: state_nx_s = ST_MUL_P;
            ST_MUL_P: state_nx_s = ST_MUL_D;
            ST_MUL_D: state_nx_s = ST_OUT;
            ST_OUT: begin
                if (Rx_En) begin
                    accept_s   = 1'b1;
                    state_nx_s = ST_DIFF;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // latch the sample on an accepted strobe
    always_ff @(posedge Clk_G or posedge Rst_G) begin
        if (Rst_G) begin
            pot_lat_r <= {W{1'b0}};
            ref_lat_r <= {W{1'b0}};
        end else if (accept_s) begin
            pot_lat_r <= $signed(Pot);
            ref_lat_r <= $signed(Ref);
        end else begin
            pot_lat_r <= pot_lat_r;
            ref_lat_r <= ref_lat_r;
        end
    end

    // error and measurement differences, widened so they cannot overflow
    always_comb begin
        e_s   = {ref_lat_r[W-1], ref_lat_r} - {pot_lat_r[W-1], pot_lat_r};
        dy_s  = {pot_lat_r[W-1], pot_lat_r} - {y1_r[W-1], y1_r};
        d2y_s = {{2{pot_lat_r[W-1]}}, pot_lat_r}
              - ({{2{y1_r[W-1]}}, y1_r} <<< 1)
              + {{2{y2_r[W-1]}}, y2_r};
    end

    // difference registers, loaded in DIFF
    always_ff @(posedge Clk_G or posedge Rst_G) begin
        if (Rst_G) begin
            e_r   <= {(W+1){1'b0}};
            dy_r  <= {(W+1){1'b0}};
            d2y_r <= {(W+2){1'b0}};
        end else if (state_r == ST_DIFF) begin
            e_r   <= e_s;
            dy_r  <= dy_s;
            d2y_r <= d2y_s;
        end else begin
            e_r   <= e_r;
            dy_r  <= dy_r;
            d2y_r <= d2y_r;
        end
    end

    // MAC operand select: +Ki*e, -Kp*dy, -Kd*d2y
    always_comb begin
        mul_a_s   = {W{1'b0}};
        mul_b_s   = {(W+2){1'b0}};
        sub_sel_s = 1'b0;
        case (state_r)
            ST_MUL_I: begin
                mul_a_s   = $signed(Ki);
                mul_b_s   = {e_r[W], e_r};
                sub_sel_s = 1'b0;
            end
            ST_MUL_P: begin
                mul_a_s   = $signed(Kp);
                mul_b_s   = {dy_r[W], dy_r};
                sub_sel_s = 1'b1;
            end
            ST_MUL_D: begin
                mul_a_s   = $signed(Kd);
                mul_b_s   = d2y_r;
                sub_sel_s = 1'b1;
            end
            default: begin
                mul_a_s   = {W{1'b0}};
                mul_b_s   = {(W+2){1'b0}};
                sub_sel_s = 1'b0;
            end
        endcase
    end

    ipd_mac #(
        .W     (W),
        .ACC_W (ACC_W)
    ) u_mac (
        .mul_a   (mul_a_s),
        .mul_b   (mul_b_s),
        .acc_in  (u_acc_r),
        .sub_sel (sub_sel_s),
        .acc_out (mac_out_s)
    );

    // round half up by F bits, then clamp to the W-bit output range
    always_comb begin
        rnd_s = {u_acc_r[ACC_W-1], u_acc_r} + RND_C;
        r_s   = rnd_s >>> frac_bits;
        if (r_s > YK_MAX_C) begin
            yk_clamp_s = YK_MAX_C[W-1:0];
            clamped_s  = 1'b1;
        end else if (r_s < YK_MIN_C) begin
            yk_clamp_s = YK_MIN_C[W-1:0];
            clamped_s  = 1'b1;
        end else begin
            yk_clamp_s = r_s[W-1:0];
            clamped_s  = 1'b0;
        end
    end

`ifdef ANTI_WINDUP_EN
    logic signed [ACC_W-1:0] reload_s;

    // clamped output scaled back into accumulator format
    always_comb begin
        reload_s = {{(ACC_W-W){yk_clamp_s[W-1]}}, yk_clamp_s} <<< frac_bits;
    end
`endif

    // integrator: cleared, accumulated in the MUL states, optionally reloaded in OUT
    always_ff @(posedge Clk_G or posedge Rst_G) begin
        if (Rst_G) begin
            u_acc_r <= {ACC_W{1'b0}};
        end else if (clear_s) begin
            u_acc_r <= {ACC_W{1'b0}};
        end else if ((state_r == ST_MUL_I) || (state_r == ST_MUL_P) || (state_r == ST_MUL_D)) begin
            u_acc_r <= mac_out_s;
`ifdef ANTI_WINDUP_EN
        end else if ((state_r == ST_OUT) && clamped_s) begin
            u_acc_r <= reload_s;
`endif
        end else begin
            u_acc_r <= u_acc_r;
        end
    end

    // measurement history for the derivative terms
    always_ff @(posedge Clk_G or posedge Rst_G) begin
        if (Rst_G) begin
            y1_r <= {W{1'b0}};
            y2_r <= {W{1'b0}};
        end else if (clear_s) begin
            y1_r <= {W{1'b0}};
            y2_r <= {W{1'b0}};
        end else if (state_r == ST_OUT) begin
            y2_r <= y1_r;
            y1_r <= pot_lat_r;
        end else begin
            y1_r <= y1_r;
            y2_r <= y2_r;
        end
    end

    // registered outputs and handshake
    always_ff @(posedge Clk_G or posedge Rst_G) begin
        if (Rst_G) begin
            yk_r   <= {W{1'b0}};
            sat_r  <= 1'b0;
            done_r <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            done_r <= (state_r == ST_OUT);
            if (state_r == ST_OUT) begin
                yk_r  <= yk_clamp_s;
                sat_r <= clamped_s;
            end else if (clear_s) begin
                yk_r  <= yk_r;
                sat_r <= 1'b0;
            end else begin
                yk_r  <= yk_r;
                sat_r <= sat_r;
            end
            if (accept_s) begin
                busy_r <= 1'b1;
            end else if (state_r == ST_OUT) begin
                busy_r <= 1'b0;
            end else begin
                busy_r <= busy_r;
            end
        end
    end

    assign Yk   = yk_r;
    assign Done = done_r;
    assign Busy = busy_r;
    assign Sat  = sat_r;

endmodule

// File: tb/tb_ipd_ctrl_sat.sv
// Directed bench for ipd_ctrl_sat (W=16, F=8) with an expected-result queue
// fed by a behavioural I-PD model at each strobe.
module tb_ipd_ctrl_sat;

    logic        Clk_G = 1'b0;
    logic        Rst_G;
    logic        Rx_En;
    logic        Clr_St;
    logic [15:0] Pot, Ref, Kp, Ki, Kd;
    logic [15:0] Yk;
    logic        Done, Busy, Sat;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] yk;
        logic        sat;
    } exp_t;
    exp_t sb_q[$];

    longint m_u, m_y1, m_y2;
    logic [15:0] last_yk;

    ipd_ctrl_sat #(.cant_bits(16), .frac_bits(8)) dut (
        .Clk_G (Clk_G), .Rst_G (Rst_G), .Rx_En (Rx_En), .Clr_St (Clr_St),
        .Pot (Pot), .Ref (Ref), .Kp (Kp), .Ki (Ki), .Kd (Kd),
        .Yk (Yk), .Done (Done), .Busy (Busy), .Sat (Sat)
    );

    always #5 Clk_G = ~Clk_G;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint sat_acc(input longint v);
        longint hi;
        hi = 64'sd34359738367;       // 2^35 - 1 for a 36-bit accumulator
        if (v > hi) return hi;
        else if (v < -hi - 64'sd1) return -hi - 64'sd1;
        else return v;
    endfunction

    // reference I-PD step on the currently driven inputs
    task automatic model_push();
        longint p, r, kp, ki, kd, e, dy, d2y, rr, ykv;
        logic   s;
        exp_t   x;
        p  = longint'($signed(Pot));
        r  = longint'($signed(Ref));
        kp = longint'($signed(Kp));
        ki = longint'($signed(Ki));
        kd = longint'($signed(Kd));
        e   = r - p;
        dy  = p - m_y1;
        d2y = p - 2 * m_y1 + m_y2;
        m_u = sat_acc(m_u + ki * e);
        m_u = sat_acc(m_u - kp * dy);
        m_u = sat_acc(m_u - kd * d2y);
        rr  = (m_u + 64'sd128) >>> 8;
        if (rr > 64'sd32767) begin
            ykv = 64'sd32767; s = 1'b1;
        end else if (rr < -64'sd32768) begin
            ykv = -64'sd32768; s = 1'b1;
        end else begin
            ykv = rr; s = 1'b0;
        end
`ifdef ANTI_WINDUP_EN
        if (s) m_u = ykv * 64'sd256;
`endif
        m_y2 = m_y1;
        m_y1 = p;
        x.yk  = 16'(ykv);
        x.sat = s;
        sb_q.push_back(x);
    endtask

    task automatic model_zero();
        m_u = 0; m_y1 = 0; m_y2 = 0;
    endtask

    // strobe one sample, wait (bounded) for Done, check latency and result
    task automatic run_sample(input string tag);
        int   lat;
        exp_t x;
        @(negedge Clk_G);
        Rx_En = 1'b1;
        model_push();
        @(posedge Clk_G);            // edge 0
        #1 Rx_En = 1'b0;
        lat = 0;
        for (int n = 1; n <= 12; n++) begin
            @(posedge Clk_G);
            #1;
            if (Done) begin
                lat = n;
                break;
            end
        end
        x = sb_q.pop_front();
        check({tag, "_latency"}, lat, 5);
        check({tag, "_yk"}, longint'($signed(Yk)), longint'($signed(x.yk)));
        check({tag, "_sat"}, Sat, x.sat);
        check({tag, "_busy_low"}, Busy, 0);
        last_yk = x.yk;
        @(posedge Clk_G);
        #1;
        check({tag, "_done_pulse"}, Done, 0);
    endtask

    task automatic clear_state(input string tag);
        @(negedge Clk_G);
        Clr_St = 1'b1;
        @(posedge Clk_G);
        #1 Clr_St = 1'b0;
        model_zero();
        check({tag, "_sat_clr"}, Sat, 0);
        check({tag, "_yk_hold"}, longint'($signed(Yk)), longint'($signed(last_yk)));
    endtask

    initial begin
        int dones, first;
        Rst_G = 1'b1; Rx_En = 1'b0; Clr_St = 1'b0;
        Pot = 16'd0; Ref = 16'd0; Kp = 16'd0; Ki = 16'd0; Kd = 16'd0;
        model_zero();
        last_yk = 16'd0;
        #10 Rst_G = 1'b0;
        #2;
        check("rst_yk", Yk, 0);
        check("rst_done", Done, 0);
        check("rst_busy", Busy, 0);
        check("rst_sat", Sat, 0);

        // integral ramp: 256, 512, 768
        Ki = 16'd256; Ref = 16'd256; Pot = 16'd0;
        for (int i = 0; i < 3; i++) begin
            run_sample("ramp");
            repeat (9) @(posedge Clk_G);
            #1;
        end

        // proportional on measurement: 0, -256, -256
        clear_state("clr_p");
        Ki = 16'd0; Kp = 16'd256; Ref = 16'd0;
        Pot = 16'd0;   run_sample("prop0");
        Pot = 16'd256; run_sample("prop1");
        run_sample("prop2");

        // derivative on measurement: 0, -256, 0
        clear_state("clr_d");
        Kp = 16'd0; Kd = 16'd256;
        Pot = 16'd0;   run_sample("der0");
        Pot = 16'd256; run_sample("der1");
        run_sample("der2");

        // saturation, then reversed error
        clear_state("clr_s");
        Kd = 16'd0; Ki = 16'h7FFF; Ref = 16'h7FFF; Pot = 16'h8000;
        for (int i = 0; i < 4; i++) run_sample("sat");
        Ki = 16'd256; Ref = 16'd0; Pot = 16'd256;
        run_sample("windup");

        // second strobe while busy is ignored: exactly one Done at edge 5
        clear_state("clr_h");
        Ki = 16'd256; Ref = 16'd256; Pot = 16'd0;
        @(negedge Clk_G);
        Rx_En = 1'b1;
        model_push();
        @(posedge Clk_G);            // edge 0
        #1 Rx_En = 1'b0;
        @(posedge Clk_G);            // edge 1
        #1 Rx_En = 1'b1;
        @(posedge Clk_G);            // edge 2
        #1 Rx_En = 1'b0;
        dones = 0; first = 0;
        for (int n = 3; n <= 14; n++) begin
            @(posedge Clk_G);
            #1;
            if (Done) begin
                dones++;
                if (first == 0) first = n;
            end
        end
        check("hs_done_count", dones, 1);
        check("hs_done_edge", first, 5);
        begin
            exp_t x;
            x = sb_q.pop_front();
            check("hs_yk", longint'($signed(Yk)), longint'($signed(x.yk)));
            last_yk = x.yk;
        end

        // clear and strobe together: strobe dropped, integrator cleared
        @(negedge Clk_G);
        Clr_St = 1'b1; Rx_En = 1'b1;
        @(posedge Clk_G);
        #1 Clr_St = 1'b0; Rx_En = 1'b0;
        model_zero();
        check("clr_rx_busy", Busy, 0);
        @(posedge Clk_G);
        #1;
        check("clr_rx_busy2", Busy, 0);
        run_sample("after_clr");

        // async reset in the middle of a computation
        @(negedge Clk_G);
        Rx_En = 1'b1;
        @(posedge Clk_G);            // edge 0
        #1 Rx_En = 1'b0;
        @(posedge Clk_G);
        @(posedge Clk_G);
        @(posedge Clk_G);            // edge 3
        #1;
        check("mid_busy_before", Busy, 1);
        Rst_G = 1'b1;
        #1;
        model_zero();
        check("mid_rst_yk", Yk, 0);
        check("mid_rst_busy", Busy, 0);
        check("mid_rst_done", Done, 0);
        check("mid_rst_sat", Sat, 0);
        @(negedge Clk_G);
        Rst_G = 1'b0;
        dones = 0;
        for (int n = 0; n < 8; n++) begin
            @(posedge Clk_G);
            #1;
            if (Done) dones++;
        end
        check("mid_rst_no_done", dones, 0);
        run_sample("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
